// File: rtl/alu_ctrl_pipe.sv
// ALU control decoder behind a STAGES-deep elastic valid/ready pipeline.
// Define ALU_CTRL_PIPE_ERR_CNT_EN to build the saturating illegal-op counter; otherwise err_count is 0.
module alu_ctrl_pipe #(
    parameter int FUNCT_W = 6,
    parameter int OP_W    = 3,
    parameter int SEL_W   = 4,
    parameter int STAGES  = 2,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [OP_W-1:0]    alu_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   select,
    output logic               illegal,
    output logic [CNT_W-1:0]   err_count
);

    logic [31:0]      op_ext;
    logic [31:0]      funct_ext;
    logic [SEL_W-1:0] dec_sel;
    logic             dec_ill;

    // Zero-extending to 32 bits makes any set upper bit fall through to the illegal default.
    always_comb begin
        op_ext    = 32'(alu_op);
        funct_ext = 32'(funct);
        dec_sel   = '0;
        dec_ill   = 1'b0;
        case (op_ext)
            32'd0: dec_sel = SEL_W'(0);
            32'd1: dec_sel = SEL_W'(1);
            32'd2: begin
                case (funct_ext)
                    32'h20, 32'h21: dec_sel = SEL_W'(0);
                    32'h22, 32'h23: dec_sel = SEL_W'(1);
                    32'h24:         dec_sel = SEL_W'(2);
                    32'h25:         dec_sel = SEL_W'(3);
                    32'h00:         dec_sel = SEL_W'(4);
                    32'h02:         dec_sel = SEL_W'(5);
                    32'h2A:         dec_sel = SEL_W'(6);
                    32'h27:         dec_sel = SEL_W'(7);
                    32'h26:         dec_sel = SEL_W'(8);
                    32'h03:         dec_sel = SEL_W'(9);
                    32'h2B:         dec_sel = SEL_W'(10);
                    default:        dec_ill = 1'b1;
                endcase
            end
            32'd3: dec_sel = SEL_W'(2);
            32'd4: dec_sel = SEL_W'(3);
            32'd5: dec_sel = SEL_W'(6);
            32'd6: dec_sel = SEL_W'(8);
            default: dec_ill = 1'b1;
        endcase
    end

    logic             valid_reg [STAGES];
    logic [SEL_W-1:0] sel_reg   [STAGES];
    logic             ill_reg   [STAGES];
    logic             up_valid  [STAGES];
    logic [SEL_W-1:0] up_sel    [STAGES];
    logic             up_ill    [STAGES];
    logic [STAGES:0]  load;
    logic             accept;

    // load[k]: slot k takes its upstream value this cycle; load[STAGES] is the ALU consuming.
    always_comb begin
        load         = '0;
        load[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            load[k] = !valid_reg[k] || load[k+1];
        end
    end

    assign in_ready = !rst && load[0];
    assign accept   = in_valid && in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign up_valid[gi] = accept;
                assign up_sel[gi]   = dec_sel;
                assign up_ill[gi]   = dec_ill;
            end else begin : g_body
                assign up_valid[gi] = valid_reg[gi-1];
                assign up_sel[gi]   = sel_reg[gi-1];
                assign up_ill[gi]   = ill_reg[gi-1];
            end

            // Bubbles carry zeroed data so an empty output reads as select 0, illegal 0.
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg[gi] <= 1'b0;
                    sel_reg[gi]   <= '0;
                    ill_reg[gi]   <= 1'b0;
                end else if (load[gi]) begin
                    valid_reg[gi] <= up_valid[gi];
                    sel_reg[gi]   <= up_valid[gi] ? up_sel[gi] : '0;
                    ill_reg[gi]   <= up_valid[gi] && up_ill[gi];
                end
            end
        end
    endgenerate

    assign out_valid = valid_reg[STAGES-1];
    assign select    = sel_reg[STAGES-1];
    assign illegal   = ill_reg[STAGES-1];

`ifdef ALU_CTRL_PIPE_ERR_CNT_EN
    logic [CNT_W-1:0] err_count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_reg <= '0;
        end else if (out_valid && out_ready && illegal && (err_count_reg != {CNT_W{1'b1}})) begin
            err_count_reg <= err_count_reg + CNT_W'(1);
        end
    end

    assign err_count = err_count_reg;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Randomised and directed bench for alu_ctrl_pipe, checked against a queue-based reference model.
module tb_alu_ctrl_pipe;

    localparam int FUNCT_W = 6;
    localparam int OP_W    = 3;
    localparam int SEL_W   = 4;
    localparam int STAGES  = 2;
    localparam int CNT_W   = 2;

    localparam int R_FN  [13] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h00, 'h02, 'h2A, 'h27, 'h26, 'h03, 'h2B};
    localparam int R_SEL [13] = '{0, 0, 1, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    localparam int OP_SEL[7]  = '{0, 1, 0, 2, 3, 6, 8};
    localparam int S1_FN [7]  = '{'h20, 'h22, 'h24, 'h25, 'h00, 'h02, 'h2A};

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [FUNCT_W-1:0] funct;
    logic [OP_W-1:0]    alu_op;
    logic               out_valid;
    logic               out_ready;
    logic [SEL_W-1:0]   select;
    logic               illegal;
    logic [CNT_W-1:0]   err_count;

    always #5 clk = ~clk;

    alu_ctrl_pipe #(
        .FUNCT_W(FUNCT_W),
        .OP_W   (OP_W),
        .SEL_W  (SEL_W),
        .STAGES (STAGES),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .funct    (funct),
        .alu_op   (alu_op),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .select   (select),
        .illegal  (illegal),
        .err_count(err_count)
    );

    typedef struct {
        int sel;
        bit ill;
        int acc;
    } op_t;

    op_t q[$];
    int  edges   = 0;
    int  err_exp = 0;
    int  errors  = 0;
    int  checks  = 0;
    int  txn     = 0;
    bit  prev_rst = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edges);
        end
    endtask

    function automatic void ref_decode(input int op, input int fn, output int sel, output bit ill);
        sel = 0;
        ill = 1'b1;
        if (op == 2) begin
            for (int i = 0; i < 13; i++) begin
                if (R_FN[i] == fn) begin
                    sel = R_SEL[i];
                    ill = 1'b0;
                end
            end
        end else if (op < 7) begin
            sel = OP_SEL[op];
            ill = 1'b0;
        end
    endfunction

    // One clock cycle: drive, check the DUT against the model, then advance the model past the next edge.
    task automatic cycle(input bit iv, input int op, input int fn, input bit ordy, input bit r);
        bit  ev;
        bit  rdy_exp;
        op_t item;
        @(negedge clk);
        in_valid  = iv;
        alu_op    = OP_W'(op);
        funct     = FUNCT_W'(fn);
        out_ready = ordy;
        rst       = r;
        #1;
        ev      = (q.size() > 0) && (edges >= q[0].acc + STAGES - 1);
        rdy_exp = !r && ((q.size() < STAGES) || ordy);
        check_eq("in_ready", in_ready, rdy_exp);
        check_eq("out_valid", out_valid, ev);
        if (ev) begin
            check_eq("select", select, q[0].sel);
            check_eq("illegal", illegal, q[0].ill);
        end
        if (prev_rst) begin
            check_eq("rst_select", select, 0);
            check_eq("rst_illegal", illegal, 0);
        end
        check_eq("err_count", err_count, err_exp);

        if (r) begin
            q.delete();
            err_exp = 0;
        end else begin
            if (ev && ordy) begin
                item = q.pop_front();
                txn++;
`ifdef ALU_CTRL_PIPE_ERR_CNT_EN
                if (item.ill && err_exp < (1 << CNT_W) - 1) err_exp++;
`endif
                $display("txn %0d: select=%0d illegal=%0d err_count_next=%0d", txn, item.sel, item.ill, err_exp);
            end
            if (iv && rdy_exp) begin
                ref_decode(op, fn, item.sel, item.ill);
                item.acc = edges + 1;
                q.push_back(item);
            end
        end
        prev_rst = r;
        edges++;
    endtask

    task automatic drain();
        repeat (STAGES + 3) cycle(1'b0, 0, 0, 1'b1, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        alu_op    = '0;
        funct     = '0;
        out_ready = 1'b1;
        @(posedge clk);
        cycle(1'b0, 0, 0, 1'b1, 1'b1);

        // R-type stream at full throughput
        foreach (S1_FN[i]) cycle(1'b1, 2, S1_FN[i], 1'b1, 1'b0);
        drain();

        // every alu_op class, then funct ignored for non-R-type
        for (int op = 0; op < 8; op++) cycle(1'b1, op, int'($urandom_range(0, 63)), 1'b1, 1'b0);
        cycle(1'b1, 0, 'h2A, 1'b1, 1'b0);
        drain();

        // backpressure: fill, hold, then release with a new op offered
        cycle(1'b1, 2, 'h20, 1'b0, 1'b0);
        cycle(1'b1, 2, 'h22, 1'b0, 1'b0);
        cycle(1'b1, 2, 'h24, 1'b0, 1'b0);
        repeat (2) cycle(1'b1, 2, 'h24, 1'b0, 1'b0);
        cycle(1'b1, 2, 'h24, 1'b1, 1'b0);
        drain();

        // saturating illegal count from a clean start
        cycle(1'b0, 0, 0, 1'b1, 1'b1);
        repeat (5) cycle(1'b1, 2, 'h3F, 1'b1, 1'b0);
        drain();

        // reset with an illegal and a legal op in flight
        cycle(1'b1, 7, 0, 1'b0, 1'b0);
        cycle(1'b1, 2, 'h20, 1'b0, 1'b0);
        cycle(1'b0, 0, 0, 1'b1, 1'b1);
        drain();

        // randomised traffic with varying stall density and rare resets
        for (int ph = 0; ph < 4; ph++) begin
            repeat (200) begin
                bit iv;
                bit ordy;
                int op;
                int fn;
                iv   = ($urandom_range(0, 3) != 0);
                ordy = ($urandom_range(0, 3) >= ph);
                op   = int'($urandom_range(0, 7));
                fn   = ($urandom_range(0, 3) != 0) ? R_FN[$urandom_range(0, 12)] : int'($urandom_range(0, 63));
                cycle(iv, op, fn, ordy, ($urandom_range(0, 149) == 0));
            end
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
